// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch stage: datapath width, the
// canonical NOP used for pipeline bubbles, and the fetch FSM states.
package riscv_pkg;

  // Datapath and address width
  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees when IF/ID holds a bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FETCH : no request outstanding
  // WAIT  : request outstanding, response will be used
  // DRAIN : request outstanding, response will be thrown away
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus. The fetch stage is the master:
// it drives a one-cycle request strobe with an address and receives a
// response strobe with the instruction word some cycles later.
interface fetch_stage_if #(
  parameter int ADDR_W = riscv_pkg::XLEN
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Loads a new {pc, instr} as a valid instruction,
// or inserts a bubble (NOP, invalid, pc kept), or holds its contents.
module if_id_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_valid
);

  import riscv_pkg::NOP_INSTR;

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;

  // Pipeline register update: reset, load, bubble, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= {XLEN{1'b0}};
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end else if (i_bubble) begin
      r_pc    <= r_pc;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= r_pc;
      r_instr <= r_instr;
      r_valid <= r_valid;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory request
// FSM with one outstanding request, a one-entry skid buffer for responses
// that arrive while decode is stalled, and the IF/ID pipeline register.
module fetch_stage #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCwrite,
  input  logic               IF_IDwrite,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid
);

  import riscv_pkg::NOP_INSTR;
  import riscv_pkg::fetch_state_e;
  import riscv_pkg::FETCH;
  import riscv_pkg::WAIT;
  import riscv_pkg::DRAIN;

  // Architectural state
  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_skid_instr;

  // Next-state and control
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] w_next_pc;
  logic            w_next_skid_valid;
  logic            w_skid_capture;
  logic            w_stall;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic            w_load;
  logic            w_bubble;
  logic [XLEN-1:0] w_load_pc;
  logic [31:0]     w_load_instr;

  // Either hazard control low freezes PC, IF/ID and the skid buffer
  assign w_stall    = !(PCwrite && IF_IDwrite);
  // Sequential PC, wrapping modulo 2^XLEN
  assign w_pc_plus4 = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
  // Redirect target forced onto a word boundary
  assign w_target   = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};

  // Next state, PC, skid buffer, IF/ID control and memory request
  always_comb begin
    w_next_state      = r_state;
    w_next_pc         = r_pc;
    w_next_skid_valid = r_skid_valid;
    w_skid_capture    = 1'b0;
    w_req             = 1'b0;
    w_addr            = r_pc;
    w_load            = 1'b0;
    w_bubble          = 1'b0;
    w_load_pc         = r_pc;
    w_load_instr      = imem.imem_rdata;

    if (branch_taken) begin
      // Redirect wins over stall: new PC, bubble, drop any buffered word
      w_next_pc         = w_target;
      w_bubble          = 1'b1;
      w_next_skid_valid = 1'b0;
      case (r_state)
        FETCH:   w_next_state = FETCH;
        WAIT:    w_next_state = imem.imem_rvalid ? FETCH : DRAIN;
        DRAIN:   w_next_state = imem.imem_rvalid ? FETCH : DRAIN;
        default: w_next_state = FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_skid_valid) begin
            // Nothing buffered: issue a request even if decode is stalled
            w_req        = 1'b1;
            w_addr       = r_pc;
            w_next_state = WAIT;
            w_bubble     = !w_stall;
          end else if (!w_stall) begin
            // Hand the buffered word to decode; fetch resumes next cycle
            w_load            = 1'b1;
            w_load_pc         = r_skid_pc;
            w_load_instr      = r_skid_instr;
            w_next_pc         = w_pc_plus4;
            w_next_skid_valid = 1'b0;
          end else begin
            w_next_state = FETCH;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (!w_stall) begin
              // Back-to-back: consume the word and request the next one
              w_load       = 1'b1;
              w_load_pc    = r_pc;
              w_load_instr = imem.imem_rdata;
              w_next_pc    = w_pc_plus4;
              w_req        = 1'b1;
              w_addr       = w_pc_plus4;
              w_next_state = WAIT;
            end else begin
              // Decode frozen: park the word in the skid buffer
              w_skid_capture    = 1'b1;
              w_next_skid_valid = 1'b1;
              w_next_state      = FETCH;
            end
          end else begin
            w_bubble = !w_stall;
          end
        end
        DRAIN: begin
          if (imem.imem_rvalid) begin
            w_next_state = FETCH;
          end else begin
            w_next_state = DRAIN;
          end
          w_bubble = !w_stall;
        end
        default: begin
          w_next_state = FETCH;
        end
      endcase
    end
  end

  // No request may leave the stage while reset is asserted
  assign imem.imem_req  = w_req && rst_n;
  assign imem.imem_addr = w_addr;

  // FSM state, program counter and skid buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= {XLEN{1'b0}};
      r_skid_instr <= NOP_INSTR;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_skid_valid <= w_next_skid_valid;
      if (w_skid_capture) begin
        r_skid_pc    <= r_pc;
        r_skid_instr <= imem.imem_rdata;
      end else begin
        r_skid_pc    <= r_skid_pc;
        r_skid_instr <= r_skid_instr;
      end
    end
  end

  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_pc     (w_load_pc),
    .i_instr  (w_load_instr),
    .o_pc     (if_id_pc),
    .o_instr  (if_id_instr),
    .o_valid  (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a behavioural memory with configurable latency
// and a queue-based reference model of which instructions must reach decode.
module tb_fetch_stage;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCwrite, IF_IDwrite, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [31:0] w_if_id_pc, w_if_id_instr;
  logic        w_if_id_valid;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(32)) imem_bus ();
  fetch_stage_if #(.ADDR_W(32)) wrap_bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem(imem_bus),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem(wrap_bus),
    .if_id_pc(w_if_id_pc), .if_id_instr(w_if_id_instr), .if_id_valid(w_if_id_valid)
  );

  typedef struct packed { logic [31:0] addr; logic keep; } req_t;

  // Reference model: requests in flight, words parked for decode, IF/ID
  req_t        inflight[$];
  req_t        held[$];
  logic [31:0] fetch_pc;
  logic        m_valid;
  logic [31:0] m_pc, m_instr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural instruction memory
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt  = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          spurious_en = 1'b0;

  logic        w_req_prev  = 1'b0;
  logic [31:0] w_addr_prev = 32'h0;
  logic [31:0] req_log[$];
  logic [31:0] out_log[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs, predict and check the request, then check IF/ID
  task automatic cycle(input logic pcw, input logic ifw, input logic bt, input logic [31:0] tgt);
    logic        stall, resp, got, idle, exp_req;
    logic [31:0] exp_addr;
    req_t        r;
    if (mem_busy && mem_cnt == 0) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = word(mem_addr);
    end else if (spurious_en && !mem_busy && $urandom_range(0, 7) == 0) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = $urandom;
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = $urandom;
    end
    PCwrite = pcw; IF_IDwrite = ifw; branch_taken = bt; branch_target = tgt;
    wrap_bus.imem_rvalid = w_req_prev;
    wrap_bus.imem_rdata  = word(w_addr_prev);
    #4;
    exp_req = 1'b0; exp_addr = 32'h0; got = 1'b0; r = '0;
    if (!rst_n) begin
      inflight.delete(); held.delete();
      fetch_pc = 32'h0; m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP_INSTR;
    end else begin
      stall = !(pcw && ifw);
      resp  = imem_bus.imem_rvalid && (inflight.size() > 0);
      idle  = (inflight.size() == 0) && (held.size() == 0);
      if (bt) begin
        if (resp) void'(inflight.pop_front());
        else if (inflight.size() > 0) inflight[0].keep = 1'b0;
        held.delete();
        fetch_pc = tgt & 32'hFFFF_FFFC;
        m_valid = 1'b0; m_instr = NOP_INSTR;
      end else begin
        if (resp) begin
          r = inflight.pop_front();
          got = r.keep;
        end
        if (got && !stall) begin
          m_valid = 1'b1; m_pc = r.addr; m_instr = word(r.addr);
          fetch_pc = r.addr + 32'd4;
          exp_req = 1'b1;
        end else if (got) begin
          held.push_back(r);
        end else if (held.size() > 0 && !stall) begin
          r = held.pop_front();
          m_valid = 1'b1; m_pc = r.addr; m_instr = word(r.addr);
          fetch_pc = r.addr + 32'd4;
        end else if (!stall) begin
          m_valid = 1'b0; m_instr = NOP_INSTR;
        end
        if (idle) exp_req = 1'b1;
        exp_addr = fetch_pc;
      end
    end
    n_tests++;
    if (imem_bus.imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_bus.imem_req, exp_req);
    end
    if (exp_req) begin
      n_tests++;
      if (imem_bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_bus.imem_addr, exp_addr);
      end
      r.addr = exp_addr; r.keep = 1'b1;
      inflight.push_back(r);
    end
    if (imem_bus.imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (!rst_n) begin
      mem_busy = 1'b0;
    end else if (imem_bus.imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_addr = imem_bus.imem_addr;
      mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
      req_log.push_back(imem_bus.imem_addr);
    end
    w_req_prev  = rst_n && (wrap_bus.imem_req === 1'b1);
    w_addr_prev = wrap_bus.imem_addr;
    @(posedge clk); #1;
    cyc++;
    n_tests++;
    if (if_id_valid !== m_valid || if_id_pc !== m_pc || if_id_instr !== m_instr) begin
      n_fail++;
      $display("FAIL if_id cyc=%0d got v=%b pc=%h i=%h exp v=%b pc=%h i=%h",
               cyc, if_id_valid, if_id_pc, if_id_instr, m_valid, m_pc, m_instr);
    end
    if (if_id_valid === 1'b1) out_log.push_back(if_id_pc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    req_log.delete(); out_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0000_0013 || if_id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_vals got v=%b pc=%h i=%h exp v=0 pc=0 i=00000013",
               if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL stream_req got n=%0d %h %h %h exp 0 4 8", req_log.size(), req_log[0], req_log[1], req_log[2]);
    end
    n_tests++;
    if (out_log.size() < 3 || out_log[0] !== 32'h0 || out_log[1] !== 32'h4 || out_log[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL stream_ifid got n=%0d %h %h %h exp 0 4 8", out_log.size(), out_log[0], out_log[1], out_log[2]);
    end
  endtask

  task automatic test_stall_skid();
    int n_before;
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_before = req_log.size();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (req_log.size() != n_before || if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold got reqs=%0d pc=%h v=%b exp reqs=%0d pc=0 v=1",
               req_log.size(), if_id_pc, if_id_valid, n_before);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release got pc=%h v=%b exp pc=4 v=1", if_id_pc, if_id_valid);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (req_log.size() != n_before + 1 || req_log[req_log.size()-1] !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_next_req got n=%0d last=%h exp last=8", req_log.size(), req_log[req_log.size()-1]);
    end
  endtask

  task automatic test_redirect_drain();
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    lat_min = 3; lat_max = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (9) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (req_log.size() < 4 || req_log[2] !== 32'h8 || req_log[3] !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_req got n=%0d r2=%h r3=%h exp 8 100", req_log.size(), req_log[2], req_log[3]);
    end
    n_tests++;
    if (out_log.size() < 3 || out_log[1] !== 32'h4 || out_log[2] !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_ifid got n=%0d o1=%h o2=%h exp 4 100", out_log.size(), out_log[1], out_log[2]);
    end
  endtask

  task automatic test_redirect_stall();
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0202);
    n_tests++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
      n_fail++;
      $display("FAIL redir_stall_bubble got v=%b i=%h exp v=0 i=00000013", if_id_valid, if_id_instr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (req_log.size() < 1 || req_log[req_log.size()-1] !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_stall_pc got %h exp 00000200", req_log[req_log.size()-1]);
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (w_req_prev !== 1'b1 || w_addr_prev !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_first got req=%b addr=%h exp 1 fffffffc", w_req_prev, w_addr_prev);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (w_req_prev !== 1'b1 || w_addr_prev !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_second got req=%b addr=%h exp 1 00000000", w_req_prev, w_addr_prev);
    end
    n_tests++;
    if (w_if_id_valid !== 1'b1 || w_if_id_pc !== 32'hFFFF_FFFC || w_if_id_instr !== word(32'hFFFF_FFFC)) begin
      n_fail++;
      $display("FAIL wrap_ifid got v=%b pc=%h i=%h exp 1 fffffffc %h",
               w_if_id_valid, w_if_id_pc, w_if_id_instr, word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_reset_in_wait();
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    req_log.delete();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (req_log.size() != 1 || req_log[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wait_req got n=%0d addr=%h exp 1 00000000", req_log.size(), req_log[0]);
    end
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic        pcw, ifw, bt;
    logic [31:0] tgt;
    lat_min = 1; lat_max = 4;
    spurious_en = 1'b1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      pcw = ($urandom_range(0, 9) != 0);
      ifw = ($urandom_range(0, 9) != 0);
      bt  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      cycle(pcw, ifw, bt, tgt);
    end
    rst_n = 1'b1;
    spurious_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; PCwrite = 1'b1; IF_IDwrite = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
    wrap_bus.imem_rvalid = 1'b0; wrap_bus.imem_rdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_drain();
    test_redirect_stall();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the program counter, issues instruction-memory requests, and holds the IF/ID pipeline register that feeds decode. It consumes the `PCwrite`/`IF_IDwrite` stall controls produced by the hazard detection unit and the taken-branch redirect from EX. It supports a variable-latency instruction memory with one outstanding request and a one-entry skid buffer for responses that arrive while decode is stalled.

## Interface
- `XLEN`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `PCwrite`  in  1  hazard unit: 0 = hold PC
- `IF_IDwrite`  in  1  hazard unit: 0 = hold IF/ID register
- `branch_taken`  in  1  EX redirect, single-cycle pulse
- `branch_target`  in  XLEN  redirect address
- `imem_req`  out  1  request strobe, one cycle per request
- `imem_addr`  out  XLEN  request address, valid while `imem_req`=1
- `imem_rvalid`  in  1  response strobe, ≥1 cycle after request
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `if_id_pc`  out  XLEN  PC of instruction in IF/ID
- `if_id_instr`  out  32  instruction in IF/ID
- `if_id_valid`  out  1  IF/ID holds a real instruction

## Operation
- Define `stall` = !(`PCwrite` & `IF_IDwrite`). `redirect` = `branch_taken`; redirect has priority over stall.
- There are three states: FETCH (no request outstanding), WAIT (request outstanding, response wanted), and DRAIN (request outstanding, response to be discarded).
- **FETCH:**
  - If the skid buffer is empty and there is no redirect: `imem_req`=1, `imem_addr`=pc, next state WAIT.
  - If the buffer is full and not stall: move the buffer into IF/ID, pc<=pc+4, clear the buffer, and stay in FETCH. No request is issued this cycle.
- **WAIT, `imem_rvalid`=1, no redirect, not stall:**
  - Load IF/ID with {pc, `imem_rdata`, valid=1} and set pc<=pc+4.
  - In the same cycle, assert `imem_req` with `imem_addr`=pc+4 and stay in WAIT. This back-to-back path gives 1 instruction/cycle with a 1-cycle memory.
- **WAIT, `imem_rvalid`=1, stall:** capture {pc, `imem_rdata`} into the skid buffer. PC and IF/ID hold. Next state FETCH; no request is issued while the buffer is full.
- **WAIT, `imem_rvalid`=0, not stall:** IF/ID loads a bubble (valid=0, instr=NOP 32'h0000_0013, pc unchanged).
- **Any state, not stall, no instruction available:** IF/ID loads a bubble.
- **Stall:** IF/ID, PC and the buffer hold their values. An outstanding request remains outstanding.
- **Redirect:**
  - pc<=`branch_target` with bits [1:0] forced to 0.
  - IF/ID gets a bubble and the skid buffer is cleared.
  - From WAIT: if `imem_rvalid`=0, go to DRAIN; if `imem_rvalid`=1, discard the response and go to FETCH.
  - From DRAIN: update pc and stay in DRAIN.
  - From FETCH: go to FETCH, with no request issued in the redirect cycle.
- **DRAIN:** `imem_req`=0. When `imem_rvalid` arrives, discard the response and go to FETCH.
- **Arithmetic:** pc+4 is computed modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- **Protocol error:** `imem_rvalid` in FETCH is ignored.

## Timing
- Reset values (`rst_n`=0 at a clock edge):
  - state FETCH, pc=`RESET_PC`, skid buffer empty.
  - `if_id_valid`=0, `if_id_instr`=32'h0000_0013, `if_id_pc`=0.
  - `imem_req`=0 during the reset cycle.
- Reset mid-request abandons the outstanding response. The memory must also be reset.
- Latency: request in cycle N, response in cycle N+k (k≥1), instruction visible on IF/ID outputs in cycle N+k+1.
- `imem_req` and `imem_addr` are combinational from state, pc, buffer status, `imem_rvalid`, stall and redirect. All IF/ID outputs are registered.
- A redirect asserted in cycle N produces the first request for the target in cycle N+1 (FETCH), or one cycle after the discarded response (DRAIN).

## Structure
- Package `riscv_pkg` holds `XLEN`, `NOP_INSTR`=32'h0000_0013, and the fetch state enum {FETCH, WAIT, DRAIN}.
- The sub-module is `if_id_reg`: IF/ID register with load, bubble and hold controls plus the reset values above. The FSM, PC and skid buffer stay in `fetch_stage`.

## Test plan
- **Reset, 1-cycle memory, no stalls:** requests at 0x0, 0x4, 0x8 on consecutive cycles; IF/ID pc 0x0, 0x4, 0x8 in consecutive cycles with valid=1.
- **Stall while response returns:** `IF_IDwrite`=`PCwrite`=0 for 3 cycles as 0x4 returns; IF/ID holds 0x0 and no `imem_req` is issued; after release, IF/ID=0x4 next cycle and then a request for 0x8.
- **Redirect with outstanding 3-cycle request:** `branch_taken` with target 0x100 one cycle after request at 0x8; response for 0x8 is discarded and never reaches IF/ID; next request is at 0x100; bubbles appear in IF/ID until 0x100 arrives.
- **Redirect and stall in the same cycle:** redirect wins; IF/ID gets a bubble; pc=0x200 for target 0x202.
- **Wrap-around:** `RESET_PC`=32'hFFFF_FFFC gives a second request at 0x0.
- **Reset asserted in WAIT:** all outputs return to reset values next cycle; first request after release is at `RESET_PC`.
